// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  // Transmitter frame states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StCleanup
  } tx_state_e;

  // Parity mode encodings; the fourth code (3) also means no parity.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Smallest usable clocks-per-bit divisor; lower requests are raised to this.
  localparam int unsigned MIN_DIV = 2;

  // True when the mode inserts a parity bit into the frame.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata_o before it is popped.
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AddrW + 1)'(Depth));
  assign empty_o = (count_o == '0);
  assign push    = wr_i & ~full_o;
  assign pop     = rd_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  // Pointer update; reset discards any queued words.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write, no reset needed on the data array.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime divisor, parity and stop-bit selection fed by an input FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [DIV_WIDTH-1:0]          i_Clks_Per_Bit,
  input  logic [1:0]                    i_Parity_Mode,
  input  logic                          i_Two_Stop,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done
);

  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop2_q, stop2_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           par_q, par_d;
  logic                 two_q, two_d;

  logic                 serial_q, active_q, done_q, overflow_q;
  logic                 line, active, done, load_req, bit_end;

  logic                 fifo_rd, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_tx_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .wr_i    (i_Tx_DV),
    .wdata_i (i_Tx_Byte),
    .rd_i    (fifo_rd),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_Fifo_Count)
  );

  // Last cycle of the current bit period.
  assign bit_end = (cnt_q == div_q - DIV_WIDTH'(1));

  // Next-state, line level and pop decision for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    stop2_d  = stop2_q;
    data_d   = data_q;
    div_d    = div_q;
    par_d    = par_q;
    two_d    = two_q;
    fifo_rd  = 1'b0;
    line     = 1'b1;
    active   = 1'b0;
    done     = 1'b0;
    load_req = 1'b0;

    unique case (state_q)
      StIdle: begin
        load_req = ~fifo_empty;
      end
      StStart: begin
        line   = 1'b0;
        active = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      StData: begin
        line   = data_q[idx_q];
        active = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            stop2_d = 1'b0;
            state_d = parity_enabled(par_q) ? StParity : StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      StParity: begin
        line   = (^data_q) ^ (par_q == PAR_ODD);
        active = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          stop2_d = 1'b0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      StStop: begin
        active = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          // Two stop bits are two back-to-back bit periods, keeping the counter DIV_WIDTH wide.
          if (two_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = StCleanup;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      StCleanup: begin
        done     = 1'b1;
        load_req = ~fifo_empty;
        if (fifo_empty) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Pop the head and capture the configuration for the whole coming frame.
    if (load_req) begin
      fifo_rd = 1'b1;
      data_d  = fifo_rdata;
      div_d   = (i_Clks_Per_Bit < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : i_Clks_Per_Bit;
      par_d   = i_Parity_Mode;
      two_d   = i_Two_Stop;
      cnt_d   = '0;
      idx_d   = '0;
      stop2_d = 1'b0;
      state_d = StStart;
    end
  end

  // Sequencer state and latched frame configuration.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop2_q <= 1'b0;
      data_q  <= '0;
      div_q   <= DIV_WIDTH'(MIN_DIV);
      par_q   <= PAR_NONE;
      two_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop2_q <= stop2_d;
      data_q  <= data_d;
      div_q   <= div_d;
      par_q   <= par_d;
      two_q   <= two_d;
    end
  end

  // Registered pin-facing outputs so the TX line is glitch-free.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      serial_q   <= line;
      active_q   <= active;
      done_q     <= done;
      overflow_q <= i_Tx_DV & fifo_full;
    end
  end

  assign o_Tx_Serial   = serial_q;
  assign o_Tx_Active   = active_q;
  assign o_Tx_Done     = done_q;
  assign o_Tx_Overflow = overflow_q;
  assign o_Tx_Ready    = ~fifo_full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table-driven frames plus corner-case sequences.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        i_Reset;
  logic [15:0] i_Clks_Per_Bit;
  logic [1:0]  i_Parity_Mode;
  logic        i_Two_Stop;
  logic        i_Tx_DV;
  logic [7:0]  i_Tx_Byte;
  logic        o_Tx_Ready, o_Tx_Overflow, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
  logic [2:0]  o_Fifo_Count;

  uart_tx_cfg #(
    .DATA_BITS  (8),
    .DIV_WIDTH  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .i_Clock        (clk),
    .i_Reset        (i_Reset),
    .i_Clks_Per_Bit (i_Clks_Per_Bit),
    .i_Parity_Mode  (i_Parity_Mode),
    .i_Two_Stop     (i_Two_Stop),
    .i_Tx_DV        (i_Tx_DV),
    .i_Tx_Byte      (i_Tx_Byte),
    .o_Tx_Ready     (o_Tx_Ready),
    .o_Tx_Overflow  (o_Tx_Overflow),
    .o_Fifo_Count   (o_Fifo_Count),
    .o_Tx_Serial    (o_Tx_Serial),
    .o_Tx_Active    (o_Tx_Active),
    .o_Tx_Done      (o_Tx_Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         n;
    logic [1:0] par;
    logic       two;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         n;
    logic [1:0] par;
    logic       two;
    int         exp_len;
    logic       has_par;
    logic       exp_par;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   frames_seen = 0;
  int   done_cnt = 0;
  int   ovf_cnt = 0;
  int   run_len = 0;
  int   last_len = 0;
  logic last_par = 1'b0;
  logic in_frame = 1'b0;
  logic mon_en = 1'b0;
  exp_t sb_q[$];
  int   start_q[$];
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int eff_n(input int n);
    return (n < 2) ? 2 : n;
  endfunction

  function automatic logic par_on(input logic [1:0] p);
    return (p == 2'd1) || (p == 2'd2);
  endfunction

  function automatic int frame_len(input exp_t e);
    return eff_n(e.n) * (10 + int'(par_on(e.par)) + int'(e.two));
  endfunction

  // Expected line level at cycle i of a frame.
  function automatic logic exp_bit(input exp_t e, input int i);
    int b;
    b = i / eff_n(e.n);
    if (b == 0) return 1'b0;
    if (b <= 8) return e.data[b-1];
    if (par_on(e.par) && b == 9) return (^e.data) ^ (e.par == 2'd2);
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and active-run length.
  always @(negedge clk) begin
    if (o_Tx_Done) done_cnt <= done_cnt + 1;
    if (o_Tx_Overflow) ovf_cnt <= ovf_cnt + 1;
    if (o_Tx_Active) run_len <= run_len + 1;
    else if (run_len > 0) begin
      last_len <= run_len;
      run_len  <= 0;
    end
  end

  // Frame monitor: pops the scoreboard on each start bit and compares every cycle.
  initial begin
    exp_t e;
    int   len, bad, pmid;
    forever begin
      @(negedge clk);
      if (mon_en && !i_Reset && o_Tx_Serial == 1'b0) begin
        in_frame = 1'b1;
        start_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=start required=idle");
          for (int i = 0; i < 20000 && o_Tx_Active; i++) @(negedge clk);
        end else begin
          e    = sb_q.pop_front();
          len  = frame_len(e);
          pmid = eff_n(e.n) * 9 + eff_n(e.n) / 2;
          bad  = 0;
          for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (o_Tx_Serial !== exp_bit(e, i) || o_Tx_Active !== 1'b1) bad++;
            if (par_on(e.par) && i == pmid) last_par = o_Tx_Serial;
          end
          chk("frame_wave", bad, 0);
          @(negedge clk);
          chk("frame_done_gap", {29'd0, o_Tx_Done, o_Tx_Serial, o_Tx_Active}, 32'b110);
          frames_seen++;
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b);
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = b;
    @(negedge clk);
    i_Tx_DV   = 1'b0;
  endtask

  task automatic set_cfg(input int n, input logic [1:0] p, input logic two);
    i_Clks_Per_Bit = 16'(n);
    i_Parity_Mode  = p;
    i_Two_Stop     = two;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !in_frame && !o_Tx_Active) break;
    end
    if (i == budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d0, f0, o0, peak;
    logic bad_line;

    tbl[0] = '{8'hA5, 4, 2'd0, 1'b0, 40, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 3, 2'd1, 1'b1, 36, 1'b1, 1'b1};
    tbl[2] = '{8'h07, 3, 2'd2, 1'b1, 36, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 1, 2'd0, 1'b0, 20, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 0, 2'd2, 1'b0, 22, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 5, 2'd3, 1'b1, 55, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 2, 2'd1, 1'b0, 22, 1'b1, 1'b1};

    i_Reset = 1'b1;
    i_Tx_DV = 1'b0;
    i_Tx_Byte = 8'h00;
    set_cfg(4, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_serial", o_Tx_Serial, 1);
    chk("reset_active_done_ovf", {o_Tx_Active, o_Tx_Done, o_Tx_Overflow}, 0);
    chk("reset_ready", o_Tx_Ready, 1);
    chk("reset_count", o_Fifo_Count, 0);
    i_Reset = 1'b0;
    mon_en  = 1'b1;
    @(negedge clk);

    // Latency: write before edge k, line still high after k+1, low after k+2.
    sb_q.push_back('{8'hA5, 4, 2'd0, 1'b0});
    d0 = done_cnt;
    write_byte(8'hA5);
    @(negedge clk);
    chk("latency_k1_high", o_Tx_Serial, 1);
    @(negedge clk);
    chk("latency_k2_low", o_Tx_Serial, 0);
    wait_idle(200);
    chk("basic_active_len", last_len, 40);
    chk("basic_done_pulses", done_cnt - d0, 1);

    // Table-driven single frames.
    for (int v = 0; v < 7; v++) begin
      set_cfg(tbl[v].n, tbl[v].par, tbl[v].two);
      sb_q.push_back('{tbl[v].data, tbl[v].n, tbl[v].par, tbl[v].two});
      write_byte(tbl[v].data);
      wait_idle(400);
      chk($sformatf("tbl%0d_len", v), last_len, tbl[v].exp_len);
      if (tbl[v].has_par) chk($sformatf("tbl%0d_parity", v), last_par, tbl[v].exp_par);
    end

    // Back-to-back burst with a one-cycle gap.
    set_cfg(2, 2'd0, 1'b0);
    start_q.delete();
    d0 = done_cnt;
    peak = 0;
    for (int b = 1; b <= 3; b++) begin
      sb_q.push_back('{8'(b), 2, 2'd0, 1'b0});
      write_byte(8'(b));
      if (int'(o_Fifo_Count) > peak) peak = int'(o_Fifo_Count);
    end
    wait_idle(400);
    chk("burst_peak_ok", (peak == 2 || peak == 3), 1);
    chk("burst_done_pulses", done_cnt - d0, 3);
    chk("burst_count_end", o_Fifo_Count, 0);
    chk("burst_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk("burst_gap_1", start_q[1] - start_q[0], 21);
      chk("burst_gap_2", start_q[2] - start_q[1], 21);
    end

    // Overflow on a depth-4 FIFO with slow frames.
    set_cfg(100, 2'd0, 1'b0);
    f0 = frames_seen;
    o0 = ovf_cnt;
    for (int b = 0; b < 6; b++) begin
      if (b < 5) sb_q.push_back('{8'h10 + 8'(b), 100, 2'd0, 1'b0});
      write_byte(8'h10 + 8'(b));
    end
    chk("ovf_full_count", o_Fifo_Count, 4);
    chk("ovf_ready_low", o_Tx_Ready, 0);
    chk("ovf_pulse_seen", o_Tx_Overflow, 1);
    wait_idle(8000);
    chk("ovf_pulses", ovf_cnt - o0, 1);
    chk("ovf_frames", frames_seen - f0, 5);

    // Mid-frame divisor change only affects the next frame.
    set_cfg(4, 2'd0, 1'b0);
    sb_q.push_back('{8'h5A, 4, 2'd0, 1'b0});
    write_byte(8'h5A);
    repeat (10) @(negedge clk);
    set_cfg(8, 2'd0, 1'b0);
    sb_q.push_back('{8'hC3, 8, 2'd0, 1'b0});
    write_byte(8'hC3);
    wait_idle(400);
    chk("cfgchg_second_len", last_len, 80);

    // Reset in the middle of the data bits with two bytes still queued.
    mon_en = 1'b0;
    set_cfg(4, 2'd0, 1'b0);
    write_byte(8'hAA);
    write_byte(8'hBB);
    write_byte(8'hCC);
    for (int i = 0; i < 50 && !o_Tx_Active; i++) @(negedge clk);
    repeat (12) @(negedge clk);
    chk("rst_pre_count", o_Fifo_Count, 2);
    chk("rst_pre_active", o_Tx_Active, 1);
    i_Reset = 1'b1;
    @(negedge clk);
    i_Reset = 1'b0;
    chk("rst_mid_serial", o_Tx_Serial, 1);
    chk("rst_mid_active", o_Tx_Active, 0);
    chk("rst_mid_count", o_Fifo_Count, 0);
    chk("rst_mid_ready", o_Tx_Ready, 1);
    bad_line = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) bad_line = 1'b1;
    end
    chk("rst_no_frame_after", bad_line, 0);

    // Normal operation resumes after reset.
    mon_en = 1'b1;
    set_cfg(3, 2'd0, 1'b0);
    sb_q.push_back('{8'h96, 3, 2'd0, 1'b0});
    write_byte(8'h96);
    wait_idle(300);
    chk("post_rst_len", last_len, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
